// File: rtl/l2_pkg.sv
// Shared types for the L1-to-L2 arbiter.
// Block layout, FSM states and port indices.
package l2_pkg;

  localparam int WORD_W    = 32;
  localparam int BLK_WORDS = 16;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef logic [BLK_WORDS-1:0][WORD_W-1:0] block_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/l2_arbiter_rr_arb2.sv
// Two-way round-robin pick.
// On a tie the port that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_idx,
  output logic       gnt_valid
);

  // Pick a winner from the current request pair.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    unique case (req)
      2'b11:   gnt_idx = ~last_grant;
      2'b10:   gnt_idx = 1'b1;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the L2 request port between I-cache and D-cache.
// Latches the winner, holds it until l2_ready, routes the reply back.
module l2_arbiter
  import l2_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 p0_addr,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] p0_data_in,
  input  logic                                  p0_read,
  input  logic                                  p0_write,
  output logic                                  p0_ready,
  output logic                                  p0_hit,
  output logic                                  p0_block_valid,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] p0_block_data,
  input  logic [ADDR_WIDTH-1:0]                 p1_addr,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] p1_data_in,
  input  logic                                  p1_read,
  input  logic                                  p1_write,
  output logic                                  p1_ready,
  output logic                                  p1_hit,
  output logic                                  p1_block_valid,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] p1_block_data,
  output logic [ADDR_WIDTH-1:0]                 l2_addr,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_data_out,
  output logic                                  l2_read,
  output logic                                  l2_write,
  input  logic                                  l2_ready,
  input  logic                                  l2_hit,
  input  logic                                  l2_block_valid,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_block_data,
  output logic                                  grant,
  output logic                                  busy,
  output logic                                  l2_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;
  logic   last_q;
  logic   grant_q;
  logic   take, done;
  logic   gnt_idx, gnt_valid;
  logic   to_q, wd_hit;
  logic [CW-1:0] cnt_q;

  rr_arb2 u_arb (
    .req        ({p1_read | p1_write, p0_read | p0_write}),
    .last_grant (last_q),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid)
  );

  assign busy       = (state_q == BUSY);
  assign grant      = grant_q;
  assign wd_hit     = busy && (cnt_q == WD_LAST);
  assign l2_timeout = to_q | wd_hit;

  // Next state: grab a winner in IDLE, release on l2_ready in BUSY.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = BUSY;
          take    = 1'b1;
        end
      end
      BUSY: begin
        if (l2_ready) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch, round-robin history and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= PORT_D;
      grant_q     <= PORT_I;
      l2_addr     <= '0;
      l2_data_out <= '0;
      l2_read     <= 1'b0;
      l2_write    <= 1'b0;
      cnt_q       <= '0;
      to_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_q | wd_hit;
      if (take) begin
        grant_q     <= gnt_idx;
        last_q      <= gnt_idx;
        l2_addr     <= gnt_idx ? p1_addr : p0_addr;
        l2_data_out <= gnt_idx ? p1_data_in : p0_data_in;
        l2_read     <= gnt_idx ? p1_read : p0_read;
        l2_write    <= gnt_idx ? p1_write : p0_write;
        cnt_q       <= '0;
      end else if (busy) begin
        if (cnt_q != WD_LAST) cnt_q <= cnt_q + 1'b1;
        if (done) begin
          l2_read  <= 1'b0;
          l2_write <= 1'b0;
        end
      end
    end
  end

  // Route the L2 reply to the owning port only.
  always_comb begin
    p0_ready       = 1'b0;
    p0_hit         = 1'b0;
    p0_block_valid = 1'b0;
    p0_block_data  = '0;
    p1_ready       = 1'b0;
    p1_hit         = 1'b0;
    p1_block_valid = 1'b0;
    p1_block_data  = '0;
    if (done) begin
      if (grant_q == PORT_D) begin
        p1_ready       = 1'b1;
        p1_hit         = l2_hit;
        p1_block_valid = l2_block_valid;
        p1_block_data  = l2_block_data;
      end else begin
        p0_ready       = 1'b1;
        p0_hit         = l2_hit;
        p0_block_valid = l2_block_valid;
        p0_block_data  = l2_block_data;
      end
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter.
// Walks the arbitration, hold, routing, watchdog and reset cases.
module tb_l2_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BS = 16;
  localparam int TO = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [AW-1:0]         p0_addr, p1_addr, l2_addr;
  logic [BS-1:0][DW-1:0] p0_data_in, p1_data_in;
  logic [BS-1:0][DW-1:0] p0_block_data, p1_block_data;
  logic [BS-1:0][DW-1:0] l2_data_out, l2_block_data;
  logic p0_read, p0_write, p0_ready, p0_hit, p0_block_valid;
  logic p1_read, p1_write, p1_ready, p1_hit, p1_block_valid;
  logic l2_read, l2_write, l2_ready, l2_hit, l2_block_valid;
  logic grant, busy, l2_timeout;

  int checks = 0;
  int errors = 0;
  int served0 = 0;
  int served1 = 0;

  logic [BS-1:0][DW-1:0] pat_a, pat_b;

  always #5 clk = ~clk;

  l2_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .p0_addr        (p0_addr),
    .p0_data_in     (p0_data_in),
    .p0_read        (p0_read),
    .p0_write       (p0_write),
    .p0_ready       (p0_ready),
    .p0_hit         (p0_hit),
    .p0_block_valid (p0_block_valid),
    .p0_block_data  (p0_block_data),
    .p1_addr        (p1_addr),
    .p1_data_in     (p1_data_in),
    .p1_read        (p1_read),
    .p1_write       (p1_write),
    .p1_ready       (p1_ready),
    .p1_hit         (p1_hit),
    .p1_block_valid (p1_block_valid),
    .p1_block_data  (p1_block_data),
    .l2_addr        (l2_addr),
    .l2_data_out    (l2_data_out),
    .l2_read        (l2_read),
    .l2_write       (l2_write),
    .l2_ready       (l2_ready),
    .l2_hit         (l2_hit),
    .l2_block_valid (l2_block_valid),
    .l2_block_data  (l2_block_data),
    .grant          (grant),
    .busy           (busy),
    .l2_timeout     (l2_timeout)
  );

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] outs();
    return {l2_read, l2_write, busy, grant, l2_timeout,
            p0_ready, p0_hit, p0_block_valid,
            p1_ready, p1_hit, p1_block_valid};
  endfunction

  initial begin
    pat_a = {BS{32'hDEAD_BEEF}};
    pat_b = {BS{32'h1234_5678}};
    p0_addr = '0; p1_addr = '0;
    p0_data_in = '0; p1_data_in = '0;
    p0_read = 0; p0_write = 0;
    p1_read = 0; p1_write = 0;
    l2_ready = 0; l2_hit = 0; l2_block_valid = 0;
    l2_block_data = '0;

    // reset state
    #12;
    chk("reset_flags", outs(), '0);
    chk("reset_addr", l2_addr, '0);
    chk("reset_p0_data", p0_block_data, '0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // l2_ready while idle is ignored
    l2_ready = 1;
    #1;
    chk("idle_ready_p0", p0_ready, 0);
    chk("idle_ready_p1", p1_ready, 0);
    tick();
    chk("idle_ready_busy", busy, 0);
    l2_ready = 0;

    // single port-0 read
    p0_addr = 32'h40;
    p0_read = 1;
    tick();
    chk("single_l2_read", l2_read, 1);
    chk("single_l2_addr", l2_addr, 32'h40);
    chk("single_grant", grant, 0);
    chk("single_p0_wait", p0_ready, 0);
    tick();
    l2_ready = 1; l2_hit = 1; l2_block_valid = 1;
    l2_block_data = pat_a;
    #1;
    chk("single_p0_resp", {p0_ready, p0_hit, p0_block_valid}, 3'b111);
    chk("single_p0_data", p0_block_data, pat_a);
    chk("single_p1_quiet",
        {p1_ready, p1_hit, p1_block_valid}, 3'b000);
    chk("single_p1_data", p1_block_data, '0);
    tick();
    p0_read = 0; l2_ready = 0; l2_hit = 0; l2_block_valid = 0;
    #1;
    chk("single_after", {l2_read, busy, p0_ready}, 3'b000);

    // tie from reset: p0 read then p1 write
    rst_n = 0;
    #1;
    rst_n = 1;
    p0_addr = 32'h80; p0_read = 1;
    p1_addr = 32'h300; p1_write = 1; p1_data_in = pat_b;
    tick();
    chk("tie_first_grant", grant, 0);
    chk("tie_first_rw", {l2_read, l2_write}, 2'b10);
    l2_ready = 1; l2_hit = 1; l2_block_valid = 1;
    #1;
    chk("tie_first_ready", {p0_ready, p1_ready}, 2'b10);
    tick();
    p0_read = 0; l2_ready = 0; l2_block_valid = 0;
    #1;
    chk("tie_gap", {busy, l2_read, l2_write}, 3'b000);
    tick();
    chk("tie_second_grant", {busy, grant}, 2'b11);
    chk("tie_second_rw", {l2_read, l2_write}, 2'b01);
    chk("tie_second_addr", l2_addr, 32'h300);
    chk("tie_second_data", l2_data_out, pat_b);
    l2_ready = 1; l2_hit = 1; l2_block_valid = 0;
    #1;
    chk("tie_second_ready", {p0_ready, p1_ready}, 2'b01);
    chk("tie_second_hit", {p1_hit, p1_block_valid}, 2'b10);
    tick();
    p1_write = 0; l2_ready = 0; l2_hit = 0;
    #1;

    // continuous re-requests alternate
    p0_read = 1; p1_read = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_grant", grant, logic'(i % 2));
      l2_ready = 1;
      #1;
      if (p0_ready) served0++;
      if (p1_ready) served1++;
      tick();
      l2_ready = 0;
      #1;
    end
    p0_read = 0; p1_read = 0;
    chk("rr_served0", served0, 4);
    chk("rr_served1", served1, 4);
    tick();

    // address held during BUSY
    p0_addr = 32'h100; p0_read = 1;
    tick();
    chk("hold_addr0", l2_addr, 32'h100);
    p0_addr = 32'h200;
    tick();
    chk("hold_addr1", l2_addr, 32'h100);
    tick();
    chk("hold_addr2", l2_addr, 32'h100);
    l2_ready = 1;
    #1;
    chk("hold_ready", p0_ready, 1);
    tick();
    p0_read = 0; l2_ready = 0;
    #1;

    // watchdog
    p1_addr = 32'h500; p1_read = 1;
    tick();
    for (int k = 1; k <= TO + 5; k++) begin
      if (k == TO - 1) chk("wd_before", l2_timeout, 0);
      if (k == TO) chk("wd_set", l2_timeout, 1);
      if (k < TO + 5) tick();
    end
    chk("wd_still_busy", {busy, grant}, 2'b11);
    l2_ready = 1; l2_block_valid = 1; l2_block_data = pat_a;
    #1;
    chk("wd_late_ready", {p0_ready, p1_ready}, 2'b01);
    chk("wd_late_data", p1_block_data, pat_a);
    tick();
    p1_read = 0; l2_ready = 0; l2_block_valid = 0;
    #1;
    chk("wd_sticky", {busy, l2_timeout}, 2'b01);

    // reset mid-transaction
    p0_addr = 32'h600; p0_read = 1;
    tick();
    chk("rst_pre_busy", {busy, grant}, 2'b10);
    p0_read = 0;
    l2_ready = 1;
    rst_n = 0;
    #1;
    chk("rst_mid_flags", outs(), '0);
    chk("rst_mid_addr", l2_addr, '0);
    l2_ready = 0;
    @(negedge clk);
    rst_n = 1;
    p0_read = 1; p1_read = 1;
    tick();
    chk("rst_tie_grant", {busy, grant}, 2'b10);
    p0_read = 0; p1_read = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
